// File: rtl/iob_ila_capture_mc.sv
// rtl/iob_ila_capture_mc.sv - ILA ring-buffer capture engine with pre-trigger window and maskable edge/level triggers
module iob_ila_capture_mc #(
  parameter int SIGNAL_W  = 32,
  parameter int TRIGGER_W = 8,
  parameter int BUFFER_W  = 4,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = (((SIGNAL_W + DATA_W - 1) / DATA_W) > 1) ?
                            $clog2((SIGNAL_W + DATA_W - 1) / DATA_W) : 1
) (
  input  logic                 clk_i,
  input  logic                 cke_i,
  input  logic                 rst_n_i,
  input  logic [SIGNAL_W-1:0]  signal_i,
  input  logic [TRIGGER_W-1:0] trigger_i,
  input  logic                 sample_en_i,
  input  logic                 arm_i,
  input  logic                 abort_i,
  input  logic [TRIGGER_W-1:0] trig_mask_i,
  input  logic [TRIGGER_W-1:0] trig_negate_i,
  input  logic [TRIGGER_W-1:0] trig_edge_i,
  input  logic                 trig_and_i,
  input  logic [BUFFER_W-1:0]  pretrig_i,
  input  logic [BUFFER_W-1:0]  rd_addr_i,
  input  logic [SEL_W-1:0]     rd_sel_i,
  output logic [DATA_W-1:0]    rd_data_o,
  output logic [2:0]           state_o,
  output logic [BUFFER_W:0]    n_samples_o,
  output logic [BUFFER_W-1:0]  trig_pos_o,
  output logic                 done_o
);

  localparam int D       = 1 << BUFFER_W;
  localparam int N_WORDS = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int N_SEL   = 1 << SEL_W;
  localparam logic [BUFFER_W:0]   FULL = (BUFFER_W + 1)'(D);
  localparam logic [BUFFER_W-1:0] LAST = BUFFER_W'(D - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                state;
  logic [BUFFER_W-1:0]   wp;
  logic [BUFFER_W-1:0]   pre_len;
  logic [BUFFER_W-1:0]   post_cnt;
  logic [BUFFER_W-1:0]   post_init;
  logic [BUFFER_W:0]     count;
  logic [BUFFER_W:0]     cnt_inc;
  logic [TRIGGER_W-1:0]  prev;
  logic [TRIGGER_W-1:0]  t;
  logic [TRIGGER_W-1:0]  hit;
  logic                  fire;
  logic                  qual;
  logic                  capturing;
  logic [BUFFER_W-1:0]   oldest;
  logic [BUFFER_W-1:0]   rd_phys;
  logic [SIGNAL_W-1:0]   mem [D];
  logic [N_WORDS*DATA_W-1:0] rd_padded;
  logic [DATA_W-1:0]     words [N_SEL];

  // Trigger qualification, saturating count and logical-to-physical read mapping
  always_comb begin
    t         = trigger_i ^ trig_negate_i;
    hit       = t & (~trig_edge_i | ~prev);
    if (trig_and_i)
      fire = (trig_mask_i != '0) && ((hit & trig_mask_i) == trig_mask_i);
    else
      fire = |(hit & trig_mask_i);
    qual      = cke_i & sample_en_i;
    capturing = (state == S_PRE) || (state == S_WAIT) || (state == S_POST);
    cnt_inc   = (count == FULL) ? count : count + (BUFFER_W + 1)'(1);
    post_init = LAST - pre_len;
    oldest    = (count == FULL) ? wp : '0;
    rd_phys   = oldest + rd_addr_i;
    rd_padded = '0;
    rd_padded[SIGNAL_W-1:0] = mem[rd_phys];
  end

  // Split the sample into readout words; selects past the last word read as zero
  for (genvar g = 0; g < N_SEL; g++) begin : g_word
    if (g < N_WORDS) begin : g_real
      assign words[g] = rd_padded[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign words[g] = '0;
    end
  end

  // Sample RAM: written only on qualified samples while capturing; never reset
  always_ff @(posedge clk_i) begin
    if (rst_n_i && qual && capturing && !abort_i)
      mem[wp] <= signal_i;
  end

  // Capture FSM, pointers, trigger history and registered read port
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      wp         <= '0;
      count      <= '0;
      post_cnt   <= '0;
      pre_len    <= '0;
      prev       <= '0;
      trig_pos_o <= '0;
      rd_data_o  <= '0;
      done_o     <= 1'b0;
    end else if (cke_i) begin
      rd_data_o <= words[rd_sel_i];
      if (qual)
        prev <= t;
      if (abort_i) begin
        state  <= S_IDLE;
        done_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_DONE: begin
            if (arm_i) begin
              pre_len    <= pretrig_i;
              trig_pos_o <= pretrig_i;
              wp         <= '0;
              count      <= '0;
              done_o     <= 1'b0;
              if (pretrig_i == '0) state <= S_WAIT;
              else                 state <= S_PRE;
            end
          end
          S_PRE: begin
            if (qual) begin
              wp    <= wp + 1'b1;
              count <= cnt_inc;
              if (cnt_inc == {1'b0, pre_len})
                state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (qual) begin
              wp    <= wp + 1'b1;
              count <= cnt_inc;
              if (fire) begin
                post_cnt <= post_init;
                if (post_init == '0) begin
                  state  <= S_DONE;
                  done_o <= 1'b1;
                end else begin
                  state <= S_POST;
                end
              end
            end
          end
          S_POST: begin
            if (qual) begin
              wp       <= wp + 1'b1;
              count    <= cnt_inc;
              post_cnt <= post_cnt - 1'b1;
              if (post_cnt == BUFFER_W'(1)) begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign state_o     = state;
  assign n_samples_o = count;

endmodule

// File: tb/tb_iob_ila_capture_mc.sv
// tb/tb_iob_ila_capture_mc.sv - self-checking bench for iob_ila_capture_mc
module tb_iob_ila_capture_mc;

  logic        clk = 0;
  logic        cke, rst_n;
  logic [39:0] sig;
  logic [7:0]  trigger, mask, negate, edge_sel;
  logic        sample_en, arm, abort, trig_and;
  logic [3:0]  pretrig, rd_addr;
  logic [0:0]  rd_sel;
  logic [31:0] rd_data, rd_data_b;
  logic [2:0]  state, state_b;
  logic [4:0]  n_samples, n_samples_b;
  logic [3:0]  trig_pos, trig_pos_b;
  logic        done, done_b;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_b_q[$];

  always #5 clk = ~clk;

  iob_ila_capture_mc #(.SIGNAL_W(40), .TRIGGER_W(8), .BUFFER_W(4), .DATA_W(32)) dut (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .signal_i(sig), .trigger_i(trigger),
    .sample_en_i(sample_en), .arm_i(arm), .abort_i(abort), .trig_mask_i(mask),
    .trig_negate_i(negate), .trig_edge_i(edge_sel), .trig_and_i(trig_and),
    .pretrig_i(pretrig), .rd_addr_i(rd_addr), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .state_o(state), .n_samples_o(n_samples), .trig_pos_o(trig_pos), .done_o(done)
  );

  iob_ila_capture_mc #(.SIGNAL_W(32), .TRIGGER_W(8), .BUFFER_W(4), .DATA_W(32)) dut_b (
    .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .signal_i(sig[31:0]), .trigger_i(trigger),
    .sample_en_i(sample_en), .arm_i(arm), .abort_i(abort), .trig_mask_i(mask),
    .trig_negate_i(negate), .trig_edge_i(edge_sel), .trig_and_i(trig_and),
    .pretrig_i(pretrig), .rd_addr_i(rd_addr), .rd_sel_i(rd_sel), .rd_data_o(rd_data_b),
    .state_o(state_b), .n_samples_o(n_samples_b), .trig_pos_o(trig_pos_b), .done_o(done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] mk_sig(input int n);
    logic [7:0] hi;
    hi = 8'(n) ^ 8'hA5;
    return {hi, 32'(n)};
  endfunction

  task automatic drive_sample(input int n, input logic [7:0] trig);
    sig = mk_sig(n);
    trigger = trig;
    sample_en = 1;
    tick();
    sample_en = 0;
  endtask

  task automatic arm_cap(input logic [3:0] p);
    pretrig = p;
    arm = 1;
    sample_en = 0;
    tick();
    arm = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    tick();
    abort = 0;
  endtask

  task automatic expect_state(input string name, input logic [2:0] exp);
    n_checks++;
    if (state !== exp) begin
      n_fail++;
      $display("FAIL %s: state_o got %0d want %0d", name, state, exp);
    end
  endtask

  task automatic read_one(input string name, input logic [3:0] a, input logic s,
                          input logic [31:0] e, input logic [31:0] eb);
    logic [31:0] w, wb;
    rd_addr = a;
    rd_sel  = s;
    exp_q.push_back(e);
    exp_b_q.push_back(eb);
    tick();
    w  = exp_q.pop_front();
    wb = exp_b_q.pop_front();
    n_checks++;
    if (rd_data !== w) begin
      n_fail++;
      $display("FAIL %s addr %0d sel %0d: rd_data got %0h want %0h", name, a, s, rd_data, w);
    end
    n_checks++;
    if (rd_data_b !== wb) begin
      n_fail++;
      $display("FAIL %s_w32 addr %0d sel %0d: rd_data got %0h want %0h", name, a, s, rd_data_b, wb);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    for (int i = 0; i < 5; i++) begin
      cke = 1'($urandom); sig = {8'($urandom), 32'($urandom)}; trigger = 8'($urandom);
      sample_en = 1'($urandom); arm = 1'($urandom); abort = 1'($urandom);
      mask = 8'($urandom); pretrig = 4'($urandom); rd_addr = 4'($urandom);
      rd_sel = 1'($urandom);
      tick();
    end
    cke = 1; arm = 0; abort = 0; sample_en = 0; trigger = 0; mask = 0;
    negate = 0; edge_sel = 0; trig_and = 0; rd_addr = 0; rd_sel = 0;
    rst_n = 1;
    expect_state("reset_state", 3'd0);
    n_checks++;
    if (n_samples !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", n_samples); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_checks++;
    if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %0h want 0", rd_data); end
    n_checks++;
    if (trig_pos !== 4'd0) begin n_fail++; $display("FAIL reset_trig_pos: got %0d want 0", trig_pos); end
  endtask

  task automatic test_pretrigger();
    logic [7:0] hi;
    mask = 8'h01; edge_sel = 0; negate = 0; trig_and = 0;
    arm_cap(4'd4);
    expect_state("pre_after_arm", 3'd1);
    for (int n = 0; n <= 21; n++) begin
      drive_sample(n, (n == 10) ? 8'h01 : 8'h00);
      if (n == 3)  expect_state("pre_to_wait", 3'd2);
      if (n == 9)  expect_state("wait_before_trig", 3'd2);
      if (n == 10) expect_state("wait_to_post", 3'd3);
      if (n == 20) expect_state("post_last_minus1", 3'd3);
    end
    expect_state("post_to_done", 3'd4);
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL done_flag: got %0b want 1", done); end
    n_checks++;
    if (n_samples !== 5'd16) begin n_fail++; $display("FAIL done_count: got %0d want 16", n_samples); end
    n_checks++;
    if (trig_pos !== 4'd4) begin n_fail++; $display("FAIL trig_pos: got %0d want 4", trig_pos); end
    for (int k = 0; k < 16; k++)
      read_one("pretrig_read", 4'(k), 1'b0, 32'(6 + k), 32'(6 + k));
    hi = 8'(10) ^ 8'hA5;
    read_one("word_sel_hi", 4'd4, 1'b1, {24'd0, hi}, 32'd0);
    read_one("word_sel_lo", 4'd4, 1'b0, 32'd10, 32'd10);
  endtask

  task automatic test_zero_pretrig();
    mask = 8'h01; edge_sel = 0;
    arm_cap(4'd0);
    expect_state("p0_straight_wait", 3'd2);
    for (int n = 0; n < 16; n++) begin
      drive_sample(n, (n == 0) ? 8'h01 : 8'h00);
      if (n == 0)  expect_state("p0_first_fire", 3'd3);
      if (n == 14) expect_state("p0_post", 3'd3);
    end
    expect_state("p0_done", 3'd4);
    read_one("p0_read0", 4'd0, 1'b0, 32'd0, 32'd0);
    read_one("p0_read15", 4'd15, 1'b0, 32'd15, 32'd15);
  endtask

  task automatic test_edge_and_mask();
    mask = 8'h01; edge_sel = 8'h01; trig_and = 0;
    drive_sample(100, 8'h01);
    arm_cap(4'd0);
    drive_sample(0, 8'h01);
    drive_sample(1, 8'h01);
    expect_state("edge_held_high", 3'd2);
    drive_sample(2, 8'h00);
    expect_state("edge_low", 3'd2);
    drive_sample(3, 8'h01);
    expect_state("edge_rise_fire", 3'd3);
    do_abort();
    expect_state("abort_in_post", 3'd0);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b want 0", done); end

    mask = 8'h03; edge_sel = 0; trig_and = 1;
    arm_cap(4'd0);
    drive_sample(0, 8'h01);
    expect_state("and_bit0_only", 3'd2);
    drive_sample(1, 8'h02);
    expect_state("and_bit1_only", 3'd2);
    drive_sample(2, 8'h03);
    expect_state("and_both", 3'd3);
    do_abort();

    mask = 8'h00;
    arm_cap(4'd0);
    for (int n = 0; n < 3; n++) drive_sample(n, 8'hFF);
    expect_state("mask0_and", 3'd2);
    trig_and = 0;
    drive_sample(3, 8'hFF);
    expect_state("mask0_or", 3'd2);
    arm_cap(4'd5);
    expect_state("arm_in_wait", 3'd2);
    n_checks++;
    if (n_samples !== 5'd4) begin n_fail++; $display("FAIL arm_in_wait_count: got %0d want 4", n_samples); end
    mask = 8'h01;
    drive_sample(4, 8'h01);
    expect_state("fire_after_ignored_arm", 3'd3);
    rst_n = 0;
    tick();
    rst_n = 1;
    expect_state("reset_mid_post", 3'd0);
    n_checks++;
    if (n_samples !== 5'd0) begin n_fail++; $display("FAIL reset_mid_post_count: got %0d want 0", n_samples); end
  endtask

  task automatic test_sample_enable();
    int cnt;
    mask = 8'h00; trigger = 0;
    arm_cap(4'd8);
    cnt = 0;
    for (int c = 0; c < 18; c++) begin
      sig = mk_sig(c);
      sample_en = (c % 3 == 0);
      tick();
      if (c % 3 == 0) cnt++;
      n_checks++;
      if (n_samples !== 5'(cnt)) begin
        n_fail++;
        $display("FAIL qual_count c=%0d: got %0d want %0d", c, n_samples, cnt);
      end
    end
    sample_en = 0;
    expect_state("qual_still_pre", 3'd1);
    for (int k = 0; k < 6; k++)
      read_one("qual_read", 4'(k), 1'b0, 32'(3 * k), 32'(3 * k));
    cke = 0; sample_en = 1; abort = 1;
    for (int i = 0; i < 4; i++) tick();
    expect_state("cke_freeze_state", 3'd1);
    n_checks++;
    if (n_samples !== 5'(cnt)) begin n_fail++; $display("FAIL cke_freeze_count: got %0d want %0d", n_samples, cnt); end
    cke = 1; sample_en = 0; abort = 0;
  endtask

  initial begin
    rd_addr = 0; rd_sel = 0; pretrig = 0; cke = 1; rst_n = 0;
    sig = 0; trigger = 0; mask = 0; negate = 0; edge_sel = 0;
    sample_en = 0; arm = 0; abort = 0; trig_and = 0;
    test_reset();
    test_pretrigger();
    test_zero_pretrig();
    test_edge_and_mask();
    test_sample_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
